// File: rtl/decode_queue.sv
// ============================================================================
// Module   : decode_queue (with package common)
// Purpose  : Instruction decode on enqueue into a DEPTH-entry in-order queue.
//            Define RV32M_EN to decode the RV32M multiply/divide group.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package common;
   typedef logic [31:0] instruction_type;

   typedef enum logic [2:0] {
      NO_TYPE = 3'd0, R_TYPE, I_TYPE, S_TYPE, B_TYPE, U_TYPE, J_TYPE
   } format_type;

   typedef enum logic [4:0] {
      ALU_ADD = 5'd0, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR, ALU_SRL,
      ALU_SRA, ALU_OR, ALU_AND, ALU_LUI, B_BNE, B_BLT, B_BGE, B_LTU, B_GEU
`ifdef RV32M_EN
      , ALU_MUL, ALU_MULH, ALU_MULHSU, ALU_MULHU, ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU
`endif
   } alu_op_type;

   typedef struct packed {
      format_type instr_type;
      alu_op_type alu_op;
      logic       reg_write;
      logic       alu_src;
      logic       mem_read;
      logic       mem_write;
      logic       mem_to_reg;
      logic       is_branch;
      logic [1:0] mem_size;
      logic       mem_sign;
   } control_type;
endpackage

module decode_queue
   import common::*;
#(
   parameter int DEPTH     = 4,
   parameter int PC_WIDTH  = 32,
   parameter int CNT_WIDTH = 16
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     flush,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [31:0]              in_instr,
   input  logic [PC_WIDTH-1:0]      in_pc,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [31:0]              out_instr,
   output logic [PC_WIDTH-1:0]      out_pc,
   output control_type              out_control,
   output logic                     out_decode_failed,
   output logic [$clog2(DEPTH):0]   count,
   output logic [CNT_WIDTH-1:0]     illegal_count
);
   localparam int c_ptr_w = $clog2(DEPTH);
   localparam logic [c_ptr_w:0] c_full = (c_ptr_w+1)'(DEPTH);

   typedef struct packed {
      instruction_type       instr;
      logic [PC_WIDTH-1:0]   pc;
      control_type           control;
      logic                  failed;
   } entry_type;

   entry_type              r_mem [DEPTH];
   logic [c_ptr_w-1:0]     r_wr_ptr;
   logic [c_ptr_w-1:0]     r_rd_ptr;
   logic [c_ptr_w:0]       r_count;
   logic [CNT_WIDTH-1:0]   r_illegal;

   control_type            w_control;
   logic                   w_failed;
   alu_op_type             w_arith;
   logic                   w_push;
   logic                   w_pop;
   entry_type              w_head;
   logic [6:0]             w_opcode;
   logic [2:0]             w_funct3;
   logic [6:0]             w_funct7;

   assign w_opcode = in_instr[6:0];
   assign w_funct3 = in_instr[14:12];
   assign w_funct7 = in_instr[31:25];

   always_comb begin
      w_control = '0;
      w_failed  = 1'b0;
      case (w_funct3)
         3'b000:  w_arith = ALU_ADD;
         3'b001:  w_arith = ALU_SLL;
         3'b010:  w_arith = ALU_SLT;
         3'b011:  w_arith = ALU_SLTU;
         3'b100:  w_arith = ALU_XOR;
         3'b101:  w_arith = ALU_SRL;
         3'b110:  w_arith = ALU_OR;
         default: w_arith = ALU_AND;
      endcase
      // The two canonical NOP words bypass opcode decode entirely
      if (in_instr != 32'h0000_0000 && in_instr != 32'h0000_1111) begin
         case (w_opcode)
            7'b0110011: begin
               w_control.instr_type = R_TYPE;
               w_control.reg_write  = 1'b1;
               if (w_funct7 == 7'b0000000)
                  w_control.alu_op = w_arith;
               else if (w_funct7 == 7'b0100000 && w_funct3 == 3'b000)
                  w_control.alu_op = ALU_SUB;
               else if (w_funct7 == 7'b0100000 && w_funct3 == 3'b101)
                  w_control.alu_op = ALU_SRA;
`ifdef RV32M_EN
               else if (w_funct7 == 7'b0000001) begin
                  case (w_funct3)
                     3'b000:  w_control.alu_op = ALU_MUL;
                     3'b001:  w_control.alu_op = ALU_MULH;
                     3'b010:  w_control.alu_op = ALU_MULHSU;
                     3'b011:  w_control.alu_op = ALU_MULHU;
                     3'b100:  w_control.alu_op = ALU_DIV;
                     3'b101:  w_control.alu_op = ALU_DIVU;
                     3'b110:  w_control.alu_op = ALU_REM;
                     default: w_control.alu_op = ALU_REMU;
                  endcase
               end
`endif
               else
                  w_failed = 1'b1;
            end
            7'b0010011: begin
               w_control.instr_type = I_TYPE;
               w_control.reg_write  = 1'b1;
               w_control.alu_src    = 1'b1;
               w_control.alu_op     = (w_funct3 == 3'b101 && in_instr[30]) ? ALU_SRA : w_arith;
            end
            7'b0000011: begin
               w_control.instr_type = I_TYPE;
               w_control.reg_write  = 1'b1;
               w_control.alu_src    = 1'b1;
               w_control.mem_read   = 1'b1;
               w_control.mem_to_reg = 1'b1;
               w_control.alu_op     = ALU_ADD;
               w_control.mem_sign   = ~w_funct3[2];
               case (w_funct3)
                  3'b000, 3'b100: w_control.mem_size = 2'b00;
                  3'b001, 3'b101: w_control.mem_size = 2'b01;
                  3'b010:         w_control.mem_size = 2'b10;
                  default:        w_failed = 1'b1;
               endcase
            end
            7'b0100011: begin
               w_control.instr_type = S_TYPE;
               w_control.alu_src    = 1'b1;
               w_control.mem_write  = 1'b1;
               w_control.alu_op     = ALU_ADD;
               w_control.mem_size   = w_funct3[1:0];
               if (w_funct3 > 3'b010)
                  w_failed = 1'b1;
            end
            7'b1100011: begin
               w_control.instr_type = B_TYPE;
               w_control.is_branch  = 1'b1;
               case (w_funct3)
                  3'b000:  w_control.alu_op = ALU_SUB;
                  3'b001:  w_control.alu_op = B_BNE;
                  3'b100:  w_control.alu_op = B_BLT;
                  3'b101:  w_control.alu_op = B_BGE;
                  3'b110:  w_control.alu_op = B_LTU;
                  3'b111:  w_control.alu_op = B_GEU;
                  default: w_failed = 1'b1;
               endcase
            end
            7'b1100111: begin
               w_control.instr_type = I_TYPE;
               w_control.is_branch  = 1'b1;
               w_control.reg_write  = 1'b1;
               w_control.alu_op     = ALU_ADD;
            end
            7'b1101111: begin
               w_control.instr_type = J_TYPE;
               w_control.reg_write  = 1'b1;
               w_control.alu_op     = ALU_ADD;
            end
            7'b0110111, 7'b0010111: begin
               w_control.instr_type = U_TYPE;
               w_control.reg_write  = 1'b1;
               w_control.alu_src    = 1'b1;
               w_control.alu_op     = w_opcode[5] ? ALU_LUI : ALU_ADD;
            end
            default: w_failed = 1'b1;
         endcase
      end
      if (w_failed)
         w_control = '0;
   end

   assign in_ready  = (r_count != c_full);
   assign out_valid = (r_count != '0);
   assign w_push    = in_valid && in_ready && !flush;
   assign w_pop     = out_valid && out_ready && !flush;
   assign w_head    = r_mem[r_rd_ptr];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++)
            r_mem[i] <= '0;
         r_wr_ptr  <= '0;
         r_rd_ptr  <= '0;
         r_count   <= '0;
         r_illegal <= '0;
      end else if (flush) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) begin
            r_mem[r_wr_ptr] <= '{instr: in_instr, pc: in_pc, control: w_control, failed: w_failed};
            r_wr_ptr        <= r_wr_ptr + 1'b1;
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + 1'b1;
            if (w_head.failed && r_illegal != '1)
               r_illegal <= r_illegal + 1'b1;
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   assign out_instr         = w_head.instr;
   assign out_pc            = w_head.pc;
   assign out_control       = w_head.control;
   assign out_decode_failed = w_head.failed;
   assign count             = r_count;
   assign illegal_count     = r_illegal;

endmodule

`default_nettype wire

// File: tb/tb_decode_queue.sv
// ============================================================================
// Module   : tb_decode_queue
// Purpose  : Scoreboard bench for decode_queue with a table-driven decode model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_decode_queue;
   import common::*;

   localparam int DEPTH     = 4;
   localparam int PC_WIDTH  = 32;
   localparam int CNT_WIDTH = 3;

   logic                  clk = 1'b0;
   logic                  reset, flush, in_valid, in_ready, out_valid, out_ready;
   logic [31:0]           in_instr, out_instr;
   logic [PC_WIDTH-1:0]   in_pc, out_pc;
   control_type           out_control;
   logic                  out_decode_failed;
   logic [$clog2(DEPTH):0] count;
   logic [CNT_WIDTH-1:0]  illegal_count;

   decode_queue #(.DEPTH(DEPTH), .PC_WIDTH(PC_WIDTH), .CNT_WIDTH(CNT_WIDTH)) dut (
      .clk(clk), .reset(reset), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
      .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr), .out_pc(out_pc),
      .out_control(out_control), .out_decode_failed(out_decode_failed),
      .count(count), .illegal_count(illegal_count)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [31:0]         instr;
      logic [PC_WIDTH-1:0] pc;
      control_type         ctrl;
      logic                failed;
   } exp_t;

   localparam alu_op_t_dummy = 0;
   localparam alu_op_type ARITH  [8] = '{ALU_ADD, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR, ALU_SRL, ALU_OR, ALU_AND};
   localparam alu_op_type BRANCH [8] = '{ALU_SUB, B_BNE, ALU_ADD, ALU_ADD, B_BLT, B_BGE, B_LTU, B_GEU};
`ifdef RV32M_EN
   localparam alu_op_type MULDIV [8] = '{ALU_MUL, ALU_MULH, ALU_MULHSU, ALU_MULHU, ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU};
`endif
   localparam logic [1:0] LD_SIZE [8] = '{2'd0, 2'd1, 2'd2, 2'd0, 2'd0, 2'd1, 2'd0, 2'd0};
   localparam logic [7:0] LD_OK = 8'b0011_0111;
   localparam logic [7:0] ST_OK = 8'b0000_0111;
   localparam logic [7:0] BR_OK = 8'b1111_0011;
   localparam logic [6:0] OPS [9] = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h67, 7'h6F, 7'h37, 7'h17};

   exp_t                 sb [$];
   exp_t                 mon_e;
   int                   tests = 0;
   int                   fails = 0;
   int                   exp_cnt = 0;
   logic [CNT_WIDTH-1:0] exp_ill = '0;
   logic [31:0]          pc = '0;
   logic                 v, rdy, fl;

   function automatic void check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endfunction

   function automatic exp_t model(input logic [31:0] w, input logic [PC_WIDTH-1:0] p);
      exp_t       e;
      logic [2:0] f3;
      logic [6:0] f7;
      f3 = w[14:12];
      f7 = w[31:25];
      e = '0;
      e.instr = w;
      e.pc    = p;
      if (w == 32'h0 || w == 32'h1111) return e;
      case (w[6:0])
         7'h33: begin
            e.ctrl.instr_type = R_TYPE;
            e.ctrl.reg_write  = 1'b1;
            if (f7 == 7'h00) e.ctrl.alu_op = ARITH[f3];
            else if (f7 == 7'h20 && f3 == 3'd0) e.ctrl.alu_op = ALU_SUB;
            else if (f7 == 7'h20 && f3 == 3'd5) e.ctrl.alu_op = ALU_SRA;
`ifdef RV32M_EN
            else if (f7 == 7'h01) e.ctrl.alu_op = MULDIV[f3];
`endif
            else e.failed = 1'b1;
         end
         7'h13: begin
            e.ctrl.instr_type = I_TYPE;
            e.ctrl.reg_write  = 1'b1;
            e.ctrl.alu_src    = 1'b1;
            e.ctrl.alu_op     = (f3 == 3'd5 && w[30]) ? ALU_SRA : ARITH[f3];
         end
         7'h03: begin
            e.ctrl.instr_type = I_TYPE;
            {e.ctrl.reg_write, e.ctrl.alu_src, e.ctrl.mem_read, e.ctrl.mem_to_reg} = 4'b1111;
            e.ctrl.alu_op   = ALU_ADD;
            e.ctrl.mem_size = LD_SIZE[f3];
            e.ctrl.mem_sign = (f3 < 3'd4);
            e.failed        = !LD_OK[f3];
         end
         7'h23: begin
            e.ctrl.instr_type = S_TYPE;
            e.ctrl.alu_src    = 1'b1;
            e.ctrl.mem_write  = 1'b1;
            e.ctrl.alu_op     = ALU_ADD;
            e.ctrl.mem_size   = f3[1:0];
            e.failed          = !ST_OK[f3];
         end
         7'h63: begin
            e.ctrl.instr_type = B_TYPE;
            e.ctrl.is_branch  = 1'b1;
            e.ctrl.alu_op     = BRANCH[f3];
            e.failed          = !BR_OK[f3];
         end
         7'h67: begin
            e.ctrl.instr_type = I_TYPE;
            e.ctrl.is_branch  = 1'b1;
            e.ctrl.reg_write  = 1'b1;
         end
         7'h6F: begin
            e.ctrl.instr_type = J_TYPE;
            e.ctrl.reg_write  = 1'b1;
         end
         7'h37, 7'h17: begin
            e.ctrl.instr_type = U_TYPE;
            e.ctrl.reg_write  = 1'b1;
            e.ctrl.alu_src    = 1'b1;
            e.ctrl.alu_op     = (w[6:0] == 7'h37) ? ALU_LUI : ALU_ADD;
         end
         default: e.failed = 1'b1;
      endcase
      if (e.failed) e.ctrl = '0;
      return e;
   endfunction

   function automatic logic [31:0] rand_instr();
      logic [31:0] r;
      logic [6:0]  op, f7;
      int          k;
      r = $urandom();
      k = int'($urandom_range(0, 19));
      if (k == 0) return 32'h0;
      if (k == 1) return 32'h1111;
      op = (k < 17) ? OPS[$urandom_range(0, 8)] : r[6:0];
      case ($urandom_range(0, 3))
         0:       f7 = 7'h00;
         1:       f7 = 7'h20;
         2:       f7 = 7'h01;
         default: f7 = r[31:25];
      endcase
      return {f7, r[24:7], op};
   endfunction

   // Monitor: every accepted head is compared against the oldest expectation
   always @(negedge clk) begin
      if (!reset && out_valid && out_ready && !flush) begin
         if (sb.size() == 0) begin
            check("unexpected_pop", 64'(out_pc), 64'hFFFF_FFFF_FFFF_FFFF);
         end else begin
            mon_e = sb.pop_front();
            check("out_instr", 64'(out_instr), 64'(mon_e.instr));
            check("out_pc", 64'(out_pc), 64'(mon_e.pc));
            check("out_control", 64'(out_control), 64'(mon_e.ctrl));
            check("out_decode_failed", 64'(out_decode_failed), 64'(mon_e.failed));
            if (mon_e.failed && exp_ill != '1) exp_ill = exp_ill + 1'b1;
         end
      end
   end

   // One cycle of stimulus; entered and left at posedge+1
   task automatic step(input logic iv, input logic [31:0] w, input logic [PC_WIDTH-1:0] p,
                       input logic rd, input logic f);
      in_valid = iv; in_instr = w; in_pc = p; out_ready = rd; flush = f;
      @(negedge clk);
      if (iv && !f && exp_cnt < DEPTH) sb.push_back(model(w, p));
      if (f) sb.delete();
      @(posedge clk);
      #1;
      exp_cnt = sb.size();
      check("count", 64'(count), 64'(exp_cnt));
      check("in_ready", 64'(in_ready), 64'(exp_cnt < DEPTH));
      check("out_valid", 64'(out_valid), 64'(exp_cnt != 0));
      check("illegal_count", 64'(illegal_count), 64'(exp_ill));
   endtask

   task automatic check_reset_values(input string tag);
      check({tag, "_count"}, 64'(count), 64'd0);
      check({tag, "_in_ready"}, 64'(in_ready), 64'd1);
      check({tag, "_out_valid"}, 64'(out_valid), 64'd0);
      check({tag, "_illegal"}, 64'(illegal_count), 64'd0);
      check({tag, "_out_instr"}, 64'(out_instr), 64'd0);
      check({tag, "_out_pc"}, 64'(out_pc), 64'd0);
      check({tag, "_out_control"}, 64'(out_control), 64'd0);
      check({tag, "_out_failed"}, 64'(out_decode_failed), 64'd0);
   endtask

   initial begin
      control_type c;
      logic [CNT_WIDTH-1:0] ill_base;
      reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      in_instr = '0; in_pc = '0;
      #12;
      check_reset_values("reset");
      @(negedge clk) reset = 1'b0;
      @(posedge clk);
      #1;

      // addi x1,x0,5 visible one cycle after the push
      step(1'b1, 32'h0050_0093, 32'h100, 1'b0, 1'b0);
      c = '0;
      c.instr_type = I_TYPE; c.alu_op = ALU_ADD; c.reg_write = 1'b1; c.alu_src = 1'b1;
      check("addi_control", 64'(out_control), 64'(c));
      check("addi_failed", 64'(out_decode_failed), 64'd0);
      step(1'b0, '0, '0, 1'b1, 1'b0);

      // Fill to DEPTH, then push+pop while full: the push must be refused
      for (int i = 0; i < DEPTH; i++) step(1'b1, 32'h0000_0033, 32'(i * 4), 1'b0, 1'b0);
      check("full_count", 64'(count), 64'(DEPTH));
      check("full_in_ready", 64'(in_ready), 64'd0);
      step(1'b1, 32'h0000_0033, 32'h40, 1'b1, 1'b0);
      check("full_pushpop_count", 64'(count), 64'(DEPTH - 1));
      for (int i = 0; i < DEPTH; i++) step(1'b0, '0, '0, 1'b1, 1'b0);

      // Two failed decodes and a NOP
      ill_base = illegal_count;
      step(1'b1, 32'h0000_307F, 32'h200, 1'b0, 1'b0);
      check("bad_opcode_failed", 64'(out_decode_failed), 64'd1);
      step(1'b1, 32'h0000_3003, 32'h204, 1'b0, 1'b0);
      step(1'b1, 32'h0000_0000, 32'h208, 1'b0, 1'b0);
      for (int i = 0; i < 4; i++) step(1'b0, '0, '0, 1'b1, 1'b0);
      check("illegal_plus_two", 64'(illegal_count), 64'(ill_base + 3'd2));

      // Flush with a simultaneous push
      for (int i = 0; i < 3; i++) step(1'b1, 32'h0000_307F, 32'(32'h300 + i * 4), 1'b0, 1'b0);
      step(1'b1, 32'h0050_0093, 32'h30C, 1'b1, 1'b1);
      check("flush_count", 64'(count), 64'd0);
      check("flush_out_valid", 64'(out_valid), 64'd0);
      check("flush_illegal", 64'(illegal_count), 64'(ill_base + 3'd2));

      // mul x3,x1,x2
      step(1'b1, 32'h0220_81B3, 32'h400, 1'b0, 1'b0);
`ifdef RV32M_EN
      c = '0; c.instr_type = R_TYPE; c.reg_write = 1'b1; c.alu_op = ALU_MUL;
      check("mul_failed", 64'(out_decode_failed), 64'd0);
`else
      c = '0;
      check("mul_failed", 64'(out_decode_failed), 64'd1);
`endif
      check("mul_control", 64'(out_control), 64'(c));
      step(1'b0, '0, '0, 1'b1, 1'b0);

      // Randomised traffic
      for (int i = 0; i < 1500; i++) begin
         v   = ($urandom_range(0, 9) < 7);
         rdy = ($urandom_range(0, 9) < 6);
         fl  = ($urandom_range(0, 49) == 0);
         step(v, rand_instr(), pc, rdy, fl);
         pc = pc + 32'd4;
      end
      for (int i = 0; i < DEPTH + 1; i++) step(1'b0, '0, '0, 1'b1, 1'b0);
      check("scoreboard_empty", 64'(sb.size()), 64'd0);
      check("illegal_saturated", 64'(illegal_count), 64'(3'h7));

      // Asynchronous reset mid-stream with two entries queued
      step(1'b1, 32'h0050_0093, 32'h500, 1'b0, 1'b0);
      step(1'b1, 32'h0000_307F, 32'h504, 1'b0, 1'b0);
      check("pre_reset_count", 64'(count), 64'd2);
      in_valid = 1'b0; out_ready = 1'b0;
      #2 reset = 1'b1;
      #1;
      check_reset_values("async_reset");
      sb.delete();
      exp_ill = '0;
      @(negedge clk) reset = 1'b0;
      @(posedge clk);
      #1;
      exp_cnt = 0;
      step(1'b1, 32'h0000_0000, 32'h600, 1'b1, 1'b0);
      step(1'b0, '0, '0, 1'b1, 1'b0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/decode_queue.md
# decode_queue

Registered instruction-decode stage with a DEPTH-entry decoded-instruction queue between fetch and the ID/EX register. Each accepted instruction is decoded once on enqueue into the common control_type bundle plus a decode_failed flag. The result is stored alongside its PC and returned in order through a valid/ready handshake. The block also supports flush and counts retired illegal instructions.

## Interface
- DEPTH, 4: queue entries; power of two, ≥2
- PC_WIDTH, 32: width of the PC carried with each entry
- CNT_WIDTH, 16: width of illegal_count
- clk  input  1  clock, all state on rising edge
- reset  input  1  asynchronous, active-high reset
- flush  input  1  discard all queued entries
- in_valid  input  1  fetch presents an instruction
- in_ready  output  1  queue can accept (count < DEPTH)
- in_instr  input  32  instruction_type word
- in_pc  input  PC_WIDTH  instruction address
- out_valid  output  1  head entry present
- out_ready  input  1  consumer takes head
- out_instr  output  32  head instruction word
- out_pc  output  PC_WIDTH  head PC
- out_control  output  control_type  head decoded control
- out_decode_failed  output  1  head failed decode
- count  output  $clog2(DEPTH)+1  occupancy
- illegal_count  output  CNT_WIDTH  saturating count of popped failed entries

## Operation
- Push when in_valid && in_ready && !flush. Pop when out_valid && out_ready && !flush.
- Decode (combinational on in_instr, captured at push); control defaults to all-zero:
  - 0110011 R_TYPE, reg_write=1
    - funct7=0000000: ADD/SLL/SLT/SLTU/XOR/SRL/OR/AND by funct3
    - funct7=0100000: SUB (funct3=000) or SRA (funct3=101); any other funct3 fails
    - any other funct7: fails (see Configuration)
  - 0010011 I_TYPE, reg_write=1, alu_src=1; ALU op by funct3; funct3=101 selects SRA when funct7[5]=1, else SRL
  - 0000011 loads: I_TYPE, reg_write, alu_src, mem_read, mem_to_reg=1, ALU_ADD
    - mem_size: 000/100 → 00, 001/101 → 01, 010 → 10
    - mem_sign = !funct3[2]
    - funct3 011/110/111 fail
  - 0100011 stores: S_TYPE, alu_src, mem_write, ALU_ADD; mem_size = funct3 for 000–010, otherwise fail
  - 1100011 branches: B_TYPE, is_branch=1
    - 000 → ALU_SUB, 001 → B_BNE, 100 → B_BLT, 101 → B_BGE, 110 → B_LTU, 111 → B_GEU
    - 010/011 fail
  - 1100111 JALR: I_TYPE, is_branch, reg_write, ALU_ADD
  - 1101111 JAL: J_TYPE, reg_write, ALU_ADD
  - 0110111 LUI: U_TYPE, reg_write, alu_src, ALU_LUI
  - 0010111 AUIPC: U_TYPE, reg_write, alu_src, ALU_ADD
  - 32'h00000000 and 32'h00001111: zero control, not failed (NOP)
  - any other opcode: fail
- A failed decode forces its control to all-zero and sets decode_failed.
- Queue is circular, pointers wrap at DEPTH. Push and pop in the same cycle leave count unchanged.
- When full, in_ready=0 even if a pop occurs that cycle (no pass-through).
- When empty, no bypass: a push becomes visible only on the following cycle.
- illegal_count increments on a pop with out_decode_failed=1 and saturates at all-ones.
- flush: next cycle count=0, out_valid=0, and pointers reset. A push or pop in the flush cycle is discarded. illegal_count is unaffected.

## Timing
- Reset: count=0, in_ready=1, out_valid=0, illegal_count=0; out_instr, out_pc, out_control and out_decode_failed are all zero.
- Latency: a push at edge N gives out_valid=1 with that entry after edge N (one cycle).
- Throughput: one push and one pop per cycle.
- While out_valid=1 && out_ready=0, all out_* outputs hold stable.
- Outputs are driven from registers or the storage array; no combinational path from in_* to out_*.
- in_ready depends only on count (registered).

## Configuration
- RV32M_EN defined: opcode 0110011 with funct7=0000001 decodes as R_TYPE, reg_write=1, with alu_op by funct3 000–111 = ALU_MUL, ALU_MULH, ALU_MULHSU, ALU_MULHU, ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU. These codes are defined in common under the same macro.
- RV32M_EN undefined: funct7=0000001 sets decode_failed=1 with zero control.

## Test plan
- Push 0x00500093 (addi x1,x0,5) after reset → next cycle out_valid=1, out_control I_TYPE/ALU_ADD/reg_write=1/alu_src=1, out_decode_failed=0.
- With out_ready=0, push DEPTH instructions → in_ready=0 and count=DEPTH. Push+pop in the same cycle while full → push refused. Afterwards drain in order with PCs 0,4,8,12.
- Push 0x0000307F (bad opcode), 0x00003003 (ld, funct3=011), 0x00000000 → failed, failed, NOP. After all three pop, illegal_count=2.
- Fill 3 entries, assert flush together with in_valid → next cycle count=0, out_valid=0, pushed word dropped, illegal_count unchanged.
- Push 0x022081B3 (mul x3,x1,x2) → ALU_MUL with RV32M_EN, decode_failed=1 without.
- Assert reset mid-stream with count=2 → all outputs at reset values immediately (asynchronous), in_ready=1.
